// File: rtl/amax10_qsys_nios2_gen2_cpu_div_cell_pkg.sv
// Shared definitions for the Nios II gen2 iterative divider.
package amax10_qsys_nios2_gen2_cpu_div_cell_pkg;

   localparam int DIV_WIDTH   = 32;
   // Edges from accept to the edge that raises done.
   localparam int DIV_LATENCY = DIV_WIDTH + 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ITER = 2'd1,
      ST_FIX  = 2'd2
   } div_state_e;

endpackage

// File: rtl/amax10_qsys_nios2_gen2_cpu_div_step.sv
// One radix-2 restoring iteration: shift in the next dividend bit, then
// subtract the divisor if it fits.
module amax10_qsys_nios2_gen2_cpu_div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] r,
   input  logic             q_msb,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] r_next,
   output logic             q_bit
);

   logic [WIDTH:0] r_sh;
   logic [WIDTH:0] d_ext;
   logic [WIDTH:0] diff;

   // The partial remainder is always below d, so r_next fits in WIDTH bits.
   always_comb begin
      r_sh   = {r, q_msb};
      d_ext  = {1'b0, d};
      diff   = r_sh - d_ext;
      q_bit  = (r_sh >= d_ext);
      r_next = q_bit ? diff[WIDTH-1:0] : r_sh[WIDTH-1:0];
   end

endmodule

// File: rtl/amax10_qsys_nios2_gen2_cpu_div_cell.sv
// Iterative div/divu unit: fixed WIDTH+1 cycle latency, start/done handshake,
// abort on pipeline flush.
module amax10_qsys_nios2_gen2_cpu_div_cell
   import amax10_qsys_nios2_gen2_cpu_div_cell_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] E_src1,
   input  logic [WIDTH-1:0] E_src2,
   input  logic             E_div_start,
   input  logic             E_div_signed,
   input  logic             E_div_abort,
   output logic             M_div_busy,
   output logic             M_div_done,
   output logic [WIDTH-1:0] M_div_quot,
   output logic [WIDTH-1:0] M_div_rem
);

   div_state_e       state;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] r, q, d, src1_raw, quot, rem;
   logic             neg_q, neg_r, dz, done;
   logic [WIDTH-1:0] r_next;
   logic             q_bit;
   logic [WIDTH-1:0] s1_abs, s2_abs;

   // Magnitudes for signed ops; abs of the most negative value is its
   // unsigned bit pattern, which gives the overflow result for free.
   always_comb begin
      s1_abs = (E_div_signed && E_src1[WIDTH-1]) ? -E_src1 : E_src1;
      s2_abs = (E_div_signed && E_src2[WIDTH-1]) ? -E_src2 : E_src2;
   end

   amax10_qsys_nios2_gen2_cpu_div_step #(.WIDTH(WIDTH)) u_step (
      .r      (r),
      .q_msb  (q[WIDTH-1]),
      .d      (d),
      .r_next (r_next),
      .q_bit  (q_bit)
   );

   // Control FSM, iteration datapath and result registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         r        <= '0;
         q        <= '0;
         d        <= '0;
         src1_raw <= '0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         dz       <= 1'b0;
         quot     <= '0;
         rem      <= '0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               // A flush in the accept cycle drops the start.
               if (E_div_start && !E_div_abort) begin
                  q        <= s1_abs;
                  d        <= s2_abs;
                  r        <= '0;
                  cnt      <= '0;
                  neg_q    <= E_div_signed & (E_src1[WIDTH-1] ^ E_src2[WIDTH-1]);
                  neg_r    <= E_div_signed & E_src1[WIDTH-1];
                  src1_raw <= E_src1;
                  dz       <= (E_src2 == '0);
                  state    <= ST_ITER;
               end
            end
            ST_ITER: begin
               if (E_div_abort) begin
                  state <= ST_IDLE;
               end else begin
                  r   <= r_next;
                  q   <= {q[WIDTH-2:0], q_bit};
                  cnt <= cnt + 1'b1;
                  if (cnt == CNT_W'(WIDTH - 1)) state <= ST_FIX;
               end
            end
            ST_FIX: begin
               state <= ST_IDLE;
               if (!E_div_abort) begin
                  // Divide-by-zero runs the full latency and then overrides.
                  quot <= dz ? '1       : (neg_q ? -q : q);
                  rem  <= dz ? src1_raw : (neg_r ? -r : r);
                  done <= 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign M_div_busy = (state != ST_IDLE);
   assign M_div_done = done;
   assign M_div_quot = quot;
   assign M_div_rem  = rem;

endmodule

// File: tb/tb_amax10_qsys_nios2_gen2_cpu_div_cell.sv
// Scoreboard bench for the div cell: the driver pushes expected results with
// their due cycle; the monitor pops and checks on every done pulse.
module tb_amax10_qsys_nios2_gen2_cpu_div_cell;
   import amax10_qsys_nios2_gen2_cpu_div_cell_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] src1 = '0, src2 = '0;
   logic        start = 1'b0, sgn = 1'b0, abort = 1'b0;
   logic        busy, done;
   logic [31:0] quot, rem;

   amax10_qsys_nios2_gen2_cpu_div_cell dut (
      .clk          (clk),
      .reset        (reset),
      .E_src1       (src1),
      .E_src2       (src2),
      .E_div_start  (start),
      .E_div_signed (sgn),
      .E_div_abort  (abort),
      .M_div_busy   (busy),
      .M_div_done   (done),
      .M_div_quot   (quot),
      .M_div_rem    (rem)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] q;
      logic [31:0] r;
      int          cyc;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!reset && done) begin
         if (sb.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("quot", quot, e.q);
            chk("rem", rem, e.r);
            chk("latency_cycle", 32'(cyc), 32'(e.cyc));
         end
      end
   end

   // Drive a start now (caller is at a negedge); accept is at the next edge.
   task automatic issue_now(input logic [31:0] a, input logic [31:0] b, input logic s,
                            input logic [31:0] eq, input logic [31:0] er, input bit expect_done);
      exp_t e;
      src1 = a; src2 = b; sgn = s; start = 1'b1;
      if (expect_done) begin
         e.q = eq; e.r = er; e.cyc = cyc + 1 + DIV_LATENCY;
         sb.push_back(e);
      end
      @(negedge clk);
      start = 1'b0;
      src1 = $urandom; src2 = $urandom; sgn = $urandom_range(0, 1);
   endtask

   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic [31:0] eq, input logic [31:0] er);
      @(negedge clk);
      issue_now(a, b, s, eq, er, 1'b1);
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0) begin
         chk("drain_timeout", 32'(sb.size()), 32'd0);
         sb.delete();
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic wait_done();
      int n = 0;
      while (!done && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!done) chk("wait_done_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      int bc;
      // Reset state
      #3;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_quot", quot, 32'd0);
      chk("rst_rem", rem, 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;

      // divu 100/7 with busy-length measurement
      issue(32'd100, 32'd7, 1'b0, 32'd14, 32'd2);
      bc = 0;
      for (int i = 0; i < 100; i++) begin
         if (busy) bc++;
         if (done) break;
         @(negedge clk);
      end
      chk("busy_cycles", 32'(bc), 32'd33);
      drain();

      // Signed, four sign combinations
      issue(32'hFFFF_FFF9, 32'd2,          1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
      drain();
      issue(32'd7,         32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD, 32'd1);
      drain();
      issue(32'hFFFF_FFF9, 32'hFFFF_FFFE,  1'b1, 32'd3,         32'hFFFF_FFFF);
      drain();
      issue(32'd7,         32'd2,          1'b1, 32'd3,         32'd1);
      drain();

      // Divide by zero
      issue(32'h1234_5678, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'h1234_5678);
      drain();
      issue(32'h8000_0000, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'h8000_0000);
      drain();

      // Overflow and extremes
      issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0);
      drain();
      issue(32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0);
      drain();

      // Start while busy is ignored (a stray done trips the monitor)
      issue(32'd1000, 32'd10, 1'b0, 32'd100, 32'd0);
      repeat (4) @(negedge clk);
      issue_now(32'd9, 32'd3, 1'b0, 32'd0, 32'd0, 1'b0);
      drain();
      repeat (40) @(negedge clk);

      // Back-to-back: new start in the done cycle
      issue(32'd50, 32'd6, 1'b0, 32'd8, 32'd2);
      wait_done();
      issue_now(32'd200, 32'd9, 1'b0, 32'd22, 32'd2, 1'b1);
      drain();

      // Abort at iteration 10: no done, results held, busy drops next cycle
      @(negedge clk);
      issue_now(32'd77, 32'd5, 1'b0, 32'd0, 32'd0, 1'b0);
      repeat (10) @(negedge clk);
      chk("busy_before_abort", 32'(busy), 32'd1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("busy_after_abort", 32'(busy), 32'd0);
      repeat (40) @(negedge clk);
      chk("abort_quot_held", quot, 32'd22);
      chk("abort_rem_held", rem, 32'd2);

      // Abort together with start in IDLE drops the start
      src1 = 32'd10; src2 = 32'd3; start = 1'b1; abort = 1'b1;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      chk("abort_start_idle", 32'(busy), 32'd0);
      repeat (40) @(negedge clk);

      // Reset mid-ITER clears everything asynchronously
      issue_now(32'd123, 32'd4, 1'b0, 32'd0, 32'd0, 1'b0);
      repeat (5) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_done", 32'(done), 32'd0);
      chk("mid_rst_quot", quot, 32'd0);
      chk("mid_rst_rem", rem, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      repeat (40) @(negedge clk);

      // Fresh operation after reset
      issue(32'hFFFF_FF9C, 32'd7, 1'b1, 32'hFFFF_FFF2, 32'hFFFF_FFFE);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

endmodule
